// File: rtl/cnet_reg_access_ctrl.sv
// PCI target to CNET register bridge: posted writes and delayed (retried) reads
// onto the CPCI->CNET request FIFO, with single outstanding read tracking.
module cnet_reg_access_ctrl #(
  parameter int PCI_ADDR_W  = 32,
  parameter int PCI_DATA_W  = 32,
  parameter int PCI_BE_W    = 4,
  parameter int CNET_ADDR_W = 27,
  parameter int CNET_DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PCI_ADDR_W-1:0]  pci_addr,
  input  logic [PCI_BE_W-1:0]    pci_be,
  input  logic [PCI_DATA_W-1:0]  pci_data,
  input  logic                   pci_data_vld,
  input  logic                   cnet_hit,
  input  logic                   cnet_we,
  output logic [PCI_DATA_W-1:0]  cnet_data,
  output logic                   cnet_vld,
  output logic                   cnet_retry,
  output logic [CNET_DATA_W-1:0] p2n_data,
  output logic [CNET_ADDR_W-1:0] p2n_addr,
  output logic                   p2n_we,
  output logic                   p2n_req,
  input  logic                   p2n_full,
  input  logic [CNET_DATA_W-1:0] n2p_data,
  input  logic                   n2p_rd_rdy,
  input  logic                   cnet_reprog
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_e;

  state_e                 state_r;
  logic [CNET_ADDR_W-1:0] rd_addr_r;
  logic [CNET_DATA_W-1:0] rd_data_r;
  logic                   served_r;

  logic match_s;
  logic retry_s;
  logic vld_s;
  logic wr_issue_s;
  logic rd_issue_s;
  logic unused_s;

  // Byte enables and the address bits above the CNET window carry no meaning here.
  assign unused_s = ^{pci_be, pci_addr[PCI_ADDR_W-1:CNET_ADDR_W]};

  // Retry/complete decision for the access currently presented by the PCI core.
  always_comb begin
    match_s    = (pci_addr[CNET_ADDR_W-1:0] == rd_addr_r);
    retry_s    = 1'b0;
    if (cnet_hit) begin
      if (p2n_full || cnet_reprog) begin
        retry_s = 1'b1;
      end else if (!cnet_we && ((state_r != RD_DONE) || !match_s)) begin
        retry_s = 1'b1;
      end else begin
        retry_s = 1'b0;
      end
    end else begin
      retry_s = 1'b0;
    end
    vld_s      = cnet_hit & ~cnet_we & ~retry_s;
    wr_issue_s = cnet_hit & cnet_we & pci_data_vld & ~retry_s;
    rd_issue_s = cnet_hit & ~cnet_we & (state_r == IDLE) & ~p2n_full & ~cnet_reprog;
  end

  assign cnet_retry = retry_s;
  assign cnet_vld   = vld_s;
  assign cnet_data  = vld_s ? PCI_DATA_W'(rd_data_r) : {PCI_DATA_W{1'b0}};

  // Request strobe generation and outstanding-read tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p2n_req   <= 1'b0;
      p2n_we    <= 1'b0;
      p2n_addr  <= {CNET_ADDR_W{1'b0}};
      p2n_data  <= {CNET_DATA_W{1'b0}};
      state_r   <= IDLE;
      rd_addr_r <= {CNET_ADDR_W{1'b0}};
      rd_data_r <= {CNET_DATA_W{1'b0}};
      served_r  <= 1'b0;
    end else begin
      p2n_req <= 1'b0;
      if (wr_issue_s) begin
        p2n_req  <= 1'b1;
        p2n_we   <= 1'b1;
        p2n_addr <= pci_addr[CNET_ADDR_W-1:0];
        p2n_data <= CNET_DATA_W'(pci_data);
      end else if (rd_issue_s) begin
        p2n_req  <= 1'b1;
        p2n_we   <= 1'b0;
        p2n_addr <= pci_addr[CNET_ADDR_W-1:0];
        p2n_data <= {CNET_DATA_W{1'b0}};
      end

      // Reprogramming aborts any read in flight; a reply landing now is dropped.
      if (cnet_reprog) begin
        state_r  <= IDLE;
        served_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (rd_issue_s) begin
              rd_addr_r <= pci_addr[CNET_ADDR_W-1:0];
              state_r   <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (n2p_rd_rdy) begin
              rd_data_r <= n2p_data;
              state_r   <= RD_DONE;
            end
          end
          RD_DONE: begin
            if (served_r && !cnet_hit) begin
              state_r  <= IDLE;
              served_r <= 1'b0;
            end else if (vld_s) begin
              served_r <= 1'b1;
            end
          end
          default: begin
            state_r  <= IDLE;
            served_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnet_reg_access_ctrl.sv
// Directed plus randomized bench for cnet_reg_access_ctrl against a
// transaction-level model of the single outstanding delayed read.
module tb_cnet_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pci_addr = 32'd0;
  logic [3:0]  pci_be = 4'hf;
  logic [31:0] pci_data = 32'd0;
  logic        pci_data_vld = 1'b0;
  logic        cnet_hit = 1'b0;
  logic        cnet_we = 1'b0;
  logic [31:0] cnet_data;
  logic        cnet_vld;
  logic        cnet_retry;
  logic [31:0] p2n_data;
  logic [26:0] p2n_addr;
  logic        p2n_we;
  logic        p2n_req;
  logic        p2n_full = 1'b0;
  logic [31:0] n2p_data = 32'd0;
  logic        n2p_rd_rdy = 1'b0;
  logic        cnet_reprog = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: one read transaction (active / reply captured / served) plus the
  // request that the FIFO port should be showing after each edge.
  bit          m_act, m_have, m_served;
  logic [26:0] m_addr;
  logic [31:0] m_data;
  bit          e_req, e_we;
  logic [26:0] e_addr;
  logic [31:0] e_data;

  always #5 clk = ~clk;

  cnet_reg_access_ctrl dut (
    .clk(clk), .reset_n(reset_n), .pci_addr(pci_addr), .pci_be(pci_be),
    .pci_data(pci_data), .pci_data_vld(pci_data_vld), .cnet_hit(cnet_hit),
    .cnet_we(cnet_we), .cnet_data(cnet_data), .cnet_vld(cnet_vld),
    .cnet_retry(cnet_retry), .p2n_data(p2n_data), .p2n_addr(p2n_addr),
    .p2n_we(p2n_we), .p2n_req(p2n_req), .p2n_full(p2n_full),
    .n2p_data(n2p_data), .n2p_rd_rdy(n2p_rd_rdy), .cnet_reprog(cnet_reprog)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit hit, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit dv);
    cnet_hit = hit; cnet_we = we; pci_addr = a; pci_data = d; pci_data_vld = dv;
  endtask

  task automatic reply(input bit rdy, input logic [31:0] d);
    n2p_rd_rdy = rdy; n2p_data = d;
  endtask

  // One clock: check the combinational answer, advance the model, check the request port.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      bit avail, r, v, wr_iss, rd_iss;
      @(negedge clk);
      avail = m_act && m_have && (pci_addr[26:0] == m_addr);
      r = cnet_hit && (p2n_full || cnet_reprog || (!cnet_we && !avail));
      v = cnet_hit && !cnet_we && !r;
      chk("retry", 32'(cnet_retry), 32'(r));
      chk("vld", 32'(cnet_vld), 32'(v));
      chk("rdata", cnet_data, v ? m_data : 32'd0);
      wr_iss = cnet_hit && cnet_we && pci_data_vld && !r;
      rd_iss = cnet_hit && !cnet_we && !m_act && !p2n_full && !cnet_reprog;
      if (cnet_reprog) begin
        m_act = 1'b0; m_served = 1'b0;
      end else if (m_act && !m_have) begin
        if (n2p_rd_rdy) begin m_have = 1'b1; m_data = n2p_data; end
      end else if (m_act && m_have) begin
        if (m_served && !cnet_hit) begin m_act = 1'b0; m_served = 1'b0; end
        else if (v) m_served = 1'b1;
      end
      e_req = 1'b0;
      if (wr_iss) begin
        e_req = 1'b1; e_we = 1'b1; e_addr = pci_addr[26:0]; e_data = pci_data;
      end else if (rd_iss) begin
        e_req = 1'b1; e_we = 1'b0; e_addr = pci_addr[26:0]; e_data = 32'd0;
        m_act = 1'b1; m_have = 1'b0; m_served = 1'b0; m_addr = pci_addr[26:0];
      end
      @(posedge clk);
      #1;
      chk("p2n_req", 32'(p2n_req), 32'(e_req));
      chk("p2n_we", 32'(p2n_we), 32'(e_we));
      chk("p2n_addr", 32'(p2n_addr), 32'(e_addr));
      chk("p2n_data", p2n_data, e_data);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    reply(1'b0, 32'd0);
    p2n_full = 1'b0; cnet_reprog = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_req", 32'(p2n_req), 32'd0);
    chk("rst_we", 32'(p2n_we), 32'd0);
    chk("rst_addr", 32'(p2n_addr), 32'd0);
    chk("rst_data", p2n_data, 32'd0);
    chk("rst_retry", 32'(cnet_retry), 32'd0);
    chk("rst_vld", 32'(cnet_vld), 32'd0);
    chk("rst_rdata", cnet_data, 32'd0);
    m_act = 1'b0; m_have = 1'b0; m_served = 1'b0; m_addr = 27'd0; m_data = 32'd0;
    e_req = 1'b0; e_we = 1'b0; e_addr = 27'd0; e_data = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] addr_tbl [4];
    addr_tbl[0] = 32'h0040_0000; addr_tbl[1] = 32'h0040_0004;
    addr_tbl[2] = 32'h0840_0000; addr_tbl[3] = 32'h0040_0010;

    do_reset();

    // Single posted write
    drive(1'b1, 1'b1, 32'h0040_0004, 32'h1, 1'b1); cyc();
    drive(1'b1, 1'b1, 32'h0040_0004, 32'h1, 1'b0); cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(2);

    // Delayed read, reply five cycles after the request
    drive(1'b1, 1'b0, 32'h0040_0000, 32'd0, 1'b0); cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(4);
    reply(1'b1, 32'h0001_c4e7); cyc();
    reply(1'b0, 32'h0); cyc();
    drive(1'b1, 1'b0, 32'h0040_0000, 32'd0, 1'b0);
    #1 chk("tp_read_data", cnet_data, 32'h0001_c4e7);
    chk("tp_read_vld", 32'(cnet_vld), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(2);

    // Ten writes then read back the last value
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, 32'h0040_0004, 32'(i), 1'b1); cyc();
    end
    drive(1'b1, 1'b0, 32'h0040_0004, 32'd0, 1'b0); cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(2);
    reply(1'b1, 32'd10); cyc();
    reply(1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'h0040_0004, 32'd0, 1'b0);
    #1 chk("tp_ten_data", cnet_data, 32'h0000_000a);
    cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(2);

    // Request FIFO full holds off a write
    p2n_full = 1'b1;
    drive(1'b1, 1'b1, 32'h0040_0008, 32'h55, 1'b1);
    #1 chk("tp_full_retry", 32'(cnet_retry), 32'd1);
    cyc(3);
    p2n_full = 1'b0; cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(2);

    // Read pending at one address, different address keeps retrying
    drive(1'b1, 1'b0, 32'h0040_0000, 32'd0, 1'b0); cyc();
    drive(1'b1, 1'b0, 32'h0040_0004, 32'd0, 1'b0); cyc(3);
    reply(1'b1, 32'hdead_beef); cyc();
    reply(1'b0, 32'd0); cyc(2);
    drive(1'b1, 1'b0, 32'h0040_0000, 32'd0, 1'b0); cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(2);

    // Reprogramming aborts a pending read; late reply ignored
    drive(1'b1, 1'b0, 32'h0040_0008, 32'd0, 1'b0); cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc();
    cnet_reprog = 1'b1;
    drive(1'b1, 1'b0, 32'h0040_0008, 32'd0, 1'b0); cyc();
    drive(1'b1, 1'b1, 32'h0040_000c, 32'h77, 1'b1); cyc();
    cnet_reprog = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc();
    reply(1'b1, 32'h1234_5678); cyc();
    reply(1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'h0040_0008, 32'd0, 1'b0); cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc();
    // Reply coincident with reprog is dropped
    cnet_reprog = 1'b1; reply(1'b1, 32'h0bad_0bad); cyc();
    cnet_reprog = 1'b0; reply(1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'h0040_0008, 32'd0, 1'b0); cyc(2);
    reply(1'b1, 32'hcafe_f00d); cyc();
    reply(1'b0, 32'd0); cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(2);

    // Reset in the middle of a read, then a late reply
    drive(1'b1, 1'b0, 32'h0040_0010, 32'd0, 1'b0); cyc();
    do_reset();
    reply(1'b1, 32'h9999_9999); cyc();
    reply(1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'h0040_0010, 32'd0, 1'b0); cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); cyc(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom % 2, addr_tbl[$urandom % 4], $urandom, $urandom % 2);
      p2n_full    = ($urandom % 8) == 0;
      cnet_reprog = ($urandom % 40) == 0;
      reply(($urandom % 6) == 0, $urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnet_reg_access_ctrl.md
# cnet_reg_access_ctrl

PCI-side register access controller that bridges PCI target accesses decoded to the CNET region onto the CPCI→CNET request FIFO interface, and returns CNET read replies to PCI. Writes are posted. Reads are delayed: the first attempt issues a request and is retried, and a later retry to the same address completes with the captured reply. It sits between the PCI target core and the CNET register interface (request FIFO / reply path).

## Interface
- PCI_ADDR_W, 32, PCI address width
- PCI_DATA_W, 32, PCI data width
- PCI_BE_W, 4, PCI byte-enable width
- CNET_ADDR_W, 27, CNET register address width
- CNET_DATA_W, 32, CNET register data width
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pci_addr  in  PCI_ADDR_W  access address
- pci_be  in  PCI_BE_W  byte enables; ignored, all accesses are full-word
- pci_data  in  PCI_DATA_W  write data
- pci_data_vld  in  1  write data valid this cycle
- cnet_hit  in  1  PCI access targets CNET region
- cnet_we  in  1  1 = write, 0 = read
- cnet_data  out  PCI_DATA_W  read data to PCI
- cnet_vld  out  1  cnet_data valid (read completes)
- cnet_retry  out  1  PCI core must retry the access
- p2n_data  out  CNET_DATA_W  request write data
- p2n_addr  out  CNET_ADDR_W  request address = pci_addr[CNET_ADDR_W-1:0]
- p2n_we  out  1  request is a write
- p2n_req  out  1  one-cycle request strobe
- p2n_full  in  1  request FIFO full
- n2p_data  in  CNET_DATA_W  read reply data
- n2p_rd_rdy  in  1  one-cycle reply strobe
- cnet_reprog  in  1  CNET being reprogrammed

## Operation
- Read FSM states: IDLE, RD_WAIT (request issued, no reply), RD_DONE (reply held in rd_data for rd_addr).
- `match` = (pci_addr[CNET_ADDR_W-1:0] == rd_addr).
- cnet_retry (combinational) = cnet_hit and any of:
  - p2n_full or cnet_reprog;
  - read (!cnet_we) and state != RD_DONE;
  - read and state == RD_DONE and !match.
- Write never retried for FSM state; writes are allowed during a pending read (FIFO keeps order).
- Write issue: rising edge with cnet_hit & cnet_we & pci_data_vld & !cnet_retry → next cycle p2n_req=1, p2n_we=1, p2n_addr, p2n_data=pci_data. One request per data_vld cycle.
- Read issue: rising edge with cnet_hit & !cnet_we & state==IDLE & !p2n_full & !cnet_reprog → next cycle p2n_req=1, p2n_we=0, p2n_data=0; rd_addr latched; state→RD_WAIT. The issuing access itself sees cnet_retry=1.
- RD_WAIT: n2p_rd_rdy → rd_data<=n2p_data, state→RD_DONE. Further read hits keep retrying and never issue a second request.
- RD_DONE: read hit with match and no full/reprog → cnet_retry=0, cnet_vld=1, cnet_data=rd_data (combinational). Set `served`. On the first cycle with !cnet_hit after served → state IDLE, served cleared.
- n2p_rd_rdy in IDLE or RD_DONE is discarded.
- cnet_reprog=1: all hits retried. A pending read is aborted: state→IDLE next edge.
- cnet_data = 0 whenever cnet_vld=0.

## Timing
- Reset (async, reset_n=0): p2n_req=0, p2n_we=0, p2n_addr=0, p2n_data=0, state=IDLE, rd_addr=0, rd_data=0, served=0. Combinational outputs: cnet_retry=0, cnet_vld=0, cnet_data=0 while cnet_hit=0.
- p2n_* are registered. p2n_req is high exactly 1 cycle, 1 cycle after the qualifying edge. p2n_addr/data/we are held until the next request.
- A read completes on the first retry after the edge where n2p_rd_rdy is sampled. The minimum is 2 cycles after issue.
- Simultaneous n2p_rd_rdy and cnet_reprog: reprog wins, and the reply is dropped.
- Reset mid-read: pending read is lost. A late reply then arrives in IDLE and is discarded.

## Test plan
- After reset, cnet_hit=1, cnet_we=1, pci_addr=0x400004, pci_data=1, one-cycle pci_data_vld → single p2n_req with p2n_we=1, p2n_addr=0x400004, p2n_data=1, and cnet_retry=0 throughout.
- Read 0x400000 → cnet_retry=1 and one p2n_req with p2n_we=0. Pulse n2p_rd_rdy with n2p_data=0x0001c4e7 five cycles later. Next retry → cnet_retry=0, cnet_vld=1, cnet_data=0x0001c4e7. Drop hit → state IDLE.
- Ten writes to 0x400004 with data 1..10, then read 0x400004 (reply 10) → ten p2n_req in order, then read returns 0x0000000a.
- p2n_full=1 during write hit → cnet_retry=1 and no p2n_req. Deassert full → write proceeds.
- Read 0x400000 pending, then read hit 0x400004 → retry with no new p2n_req. After reply, 0x400004 is still retried and 0x400000 completes.
- cnet_reprog=1 during RD_WAIT → retries on all hits, state IDLE. A subsequent reply is discarded, and the next read issues a fresh request.
